trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/MRET sequencer. Arbitrates exceptions, MRET and
// interrupts at an instruction boundary and produces the CSR write data. It
// then holds a fetch redirect until fetch accepts it. All outputs are
// registered.
module trap_ctrl #(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic        retire_valid_i,
    input  logic [31:0] next_pc_i,

    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic        sw_irq_i,

    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,

    output logic        trap_we_o,
    output logic        mret_we_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mtval_o,
    output logic [31:0] mstatus_o,
    output logic [31:0] mip_o,
    output logic        is_int_o,
    output logic        stall_o,
    output logic        flush_o,

    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP     = 2'd1,
        MRET     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [IRQ_SYNC_STAGES-1:0] ext_sync_q;
    logic                       timer_q, sw_q;

    logic [31:0] pend;
    logic        irq_take;
    logic [3:0]  irq_code;
    logic        take_exc, take_mret, take_irq;
    logic        ld_trap, ld_mret;

    logic [31:0] trap_base, trap_tgt, mret_tgt;
    logic [31:0] trap_mstatus, mret_mstatus;
    logic        unused_pend;

    // External IRQ is asynchronous: pass it through a flop chain; timer/sw
    // are already synchronous and only need one register stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ext_sync_q <= '0;
            timer_q    <= 1'b0;
            sw_q       <= 1'b0;
        end else begin
            ext_sync_q <= {ext_sync_q[IRQ_SYNC_STAGES-2:0], ext_irq_i};
            timer_q    <= timer_irq_i;
            sw_q       <= sw_irq_i;
        end
    end

    assign mip_o = {20'b0, ext_sync_q[IRQ_SYNC_STAGES-1], 3'b0, timer_q, 3'b0, sw_q, 3'b0};

    // Interrupt qualification and fixed priority MEI > MSI > MTI.
    assign pend        = mip_o & mie_i;
    assign unused_pend = ^{pend[31:12], pend[10:8], pend[6:4], pend[2:0]};
    assign irq_take    = retire_valid_i && mstatus_i[3] && (pend[11] || pend[7] || pend[3]);
    assign irq_code    = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);

    // Targets: vectoring only applies to interrupts with mtvec mode 01.
    assign trap_base = mtvec_i & 32'hFFFF_FFFC;
    assign trap_tgt  = (!take_exc && mtvec_i[1:0] == 2'b01)
                     ? trap_base + {26'b0, irq_code, 2'b00}
                     : trap_base;
    assign mret_tgt  = mepc_i & 32'hFFFF_FFFC;

    // mstatus updates: trap stacks MIE into MPIE; MRET pops it back.
    always_comb begin
        trap_mstatus        = mstatus_i;
        trap_mstatus[7]     = mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        mret_mstatus        = mstatus_i;
        mret_mstatus[3]     = mstatus_i[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and event selection; events only matter in IDLE.
    always_comb begin
        state_d   = state_q;
        take_exc  = 1'b0;
        take_mret = 1'b0;
        take_irq  = 1'b0;
        ld_trap   = 1'b0;
        ld_mret   = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_valid_i) begin
                    take_exc = 1'b1;
                    ld_trap  = 1'b1;
                    state_d  = TRAP;
                end else if (mret_i) begin
                    take_mret = 1'b1;
                    ld_mret   = 1'b1;
                    state_d   = MRET;
                end else if (irq_take) begin
                    take_irq = 1'b1;
                    ld_trap  = 1'b1;
                    state_d  = TRAP;
                end
            end
            TRAP:     state_d = REDIRECT;
            MRET:     state_d = REDIRECT;
            REDIRECT: if (redirect_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Registered outputs: strobes follow the next state, write data and the
    // redirect target are captured once at the event and then held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trap_we_o        <= 1'b0;
            mret_we_o        <= 1'b0;
            flush_o          <= 1'b0;
            stall_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            mepc_o           <= '0;
            mcause_o         <= '0;
            mtval_o          <= '0;
            mstatus_o        <= '0;
            is_int_o         <= 1'b0;
        end else begin
            trap_we_o        <= (state_d == TRAP);
            mret_we_o        <= (state_d == MRET);
            flush_o          <= (state_d == TRAP) || (state_d == MRET);
            stall_o          <= (state_d != IDLE);
            redirect_valid_o <= (state_d == REDIRECT);
            if (ld_trap) begin
                mepc_o        <= take_exc ? exc_pc_i : next_pc_i;
                mcause_o      <= take_exc ? {28'b0, exc_cause_i} : {1'b1, 27'b0, irq_code};
                mtval_o       <= take_exc ? exc_tval_i : 32'h0;
                is_int_o      <= take_irq;
                mstatus_o     <= trap_mstatus;
                redirect_pc_o <= trap_tgt;
            end else if (ld_mret) begin
                mstatus_o     <= mret_mstatus;
                redirect_pc_o <= take_mret ? mret_tgt : redirect_pc_o;
            end
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vector table for trap/MRET/interrupt entry plus
// hand-written sequences for reset, masking, backpressure and reset in REDIRECT.
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        exc_valid_i, mret_i, retire_valid_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i, next_pc_i;
    logic        ext_irq_i, timer_irq_i, sw_irq_i;
    logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
    logic        trap_we_o, mret_we_o, is_int_o, stall_o, flush_o;
    logic [31:0] mepc_o, mcause_o, mtval_o, mstatus_o, mip_o;
    logic        redirect_valid_o, redirect_ready_i;
    logic [31:0] redirect_pc_o;

    int checks   = 0;
    int failures = 0;

    trap_ctrl #(.IRQ_SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .mret_i(mret_i), .retire_valid_i(retire_valid_i),
        .next_pc_i(next_pc_i), .ext_irq_i(ext_irq_i), .timer_irq_i(timer_irq_i),
        .sw_irq_i(sw_irq_i), .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i),
        .mepc_i(mepc_i), .trap_we_o(trap_we_o), .mret_we_o(mret_we_o), .mepc_o(mepc_o),
        .mcause_o(mcause_o), .mtval_o(mtval_o), .mstatus_o(mstatus_o), .mip_o(mip_o),
        .is_int_o(is_int_o), .stall_o(stall_o), .flush_o(flush_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // All fields are 32 bits so the table literals need no sizing.
    typedef struct {
        bit [31:0] exc, cause, pc, tval, mret, retire, npc, mstatus, mie, mtvec, mepc, ext, timer, sw;
        bit [31:0] e_trap, e_mret, e_cause, e_mepc, e_mtval, e_mstat, e_int, e_rpc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_events();
        exc_valid_i = 1'b0; mret_i = 1'b0; retire_valid_i = 1'b0;
        exc_cause_i = '0; exc_pc_i = '0; exc_tval_i = '0; next_pc_i = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        ext_irq_i = v.ext[0]; timer_irq_i = v.timer[0]; sw_irq_i = v.sw[0];
        mstatus_i = v.mstatus; mie_i = v.mie; mtvec_i = v.mtvec; mepc_i = v.mepc;
        redirect_ready_i = 1'b1;
        clear_events();
        repeat (4) step();
        exc_valid_i = v.exc[0]; exc_cause_i = v.cause[3:0]; exc_pc_i = v.pc;
        exc_tval_i = v.tval; mret_i = v.mret[0]; retire_valid_i = v.retire[0];
        next_pc_i = v.npc;
        step();
        clear_events();
        chk({tag, " trap_we"}, {31'b0, trap_we_o}, v.e_trap);
        chk({tag, " mret_we"}, {31'b0, mret_we_o}, v.e_mret);
        chk({tag, " flush"}, {31'b0, flush_o}, 32'd1);
        chk({tag, " stall"}, {31'b0, stall_o}, 32'd1);
        chk({tag, " mstatus"}, mstatus_o, v.e_mstat);
        if (v.e_trap != 0) begin
            chk({tag, " mcause"}, mcause_o, v.e_cause);
            chk({tag, " mepc"}, mepc_o, v.e_mepc);
            chk({tag, " mtval"}, mtval_o, v.e_mtval);
            chk({tag, " is_int"}, {31'b0, is_int_o}, v.e_int);
        end
        step();
        chk({tag, " rd_valid"}, {31'b0, redirect_valid_o}, 32'd1);
        chk({tag, " rd_pc"}, redirect_pc_o, v.e_rpc);
        chk({tag, " rd_we"}, {30'b0, trap_we_o, mret_we_o}, 32'd0);
        step();
        chk({tag, " idle"}, {30'b0, redirect_valid_o, stall_o}, 32'd0);
        ext_irq_i = 1'b0; timer_irq_i = 1'b0; sw_irq_i = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        //           exc cause pc         tval      mret ret npc          mstatus       mie        mtvec         mepc          ext tmr sw  trap mret cause          mepc       mtval     mstat         int rpc
        vecs[0] = '{1, 2,  32'h100, 32'hDEAD, 0, 0, 0,           32'h8,        0,         32'h200,      0,            0, 0, 0, 1, 0, 32'h2,        32'h100,   32'hDEAD, 32'h1880,     0, 32'h200};
        vecs[1] = '{0, 0,  0,       0,        0, 1, 32'h44,      32'h8,        32'h80,    32'h201,      0,            0, 1, 0, 1, 0, 32'h80000007, 32'h44,    0,        32'h1880,     1, 32'h21C};
        vecs[2] = '{1, 5,  32'h500, 32'h11,   1, 1, 32'h600,     32'h8,        32'h800,   32'h300,      0,            1, 0, 0, 1, 0, 32'h5,        32'h500,   32'h11,   32'h1880,     0, 32'h300};
        vecs[3] = '{0, 0,  0,       0,        0, 1, 32'h80,      32'h8,        32'h880,   32'h1001,     0,            1, 1, 0, 1, 0, 32'h8000000B, 32'h80,    0,        32'h1880,     1, 32'h102C};
        vecs[4] = '{0, 0,  0,       0,        0, 1, 32'h90,      32'h8,        32'h88,    32'h401,      0,            0, 1, 1, 1, 0, 32'h80000003, 32'h90,    0,        32'h1880,     1, 32'h40C};
        vecs[5] = '{1, 11, 32'h7FC, 0,        0, 0, 0,           0,            0,         32'h201,      0,            0, 0, 0, 1, 0, 32'hB,        32'h7FC,   0,        32'h1800,     0, 32'h200};
        vecs[6] = '{0, 0,  0,       0,        0, 1, 32'h1234,    32'hFFFFFFFF, 32'h800,   32'hFFFFFFFD, 0,            1, 0, 0, 1, 0, 32'h8000000B, 32'h1234,  0,        32'hFFFFFFF7, 1, 32'h28};
        vecs[7] = '{0, 0,  0,       0,        1, 0, 0,           32'h80,       0,         32'h200,      32'h303,      0, 0, 0, 0, 1, 0,            0,         0,        32'h1888,     0, 32'h300};
        vecs[8] = '{0, 0,  0,       0,        1, 0, 0,           32'h8,        0,         0,            32'hABCDEF02, 0, 0, 0, 0, 1, 0,            0,         0,        32'h1880,     0, 32'hABCDEF00};
        vecs[9] = '{0, 0,  0,       0,        0, 1, 32'h10,      32'h8,        32'h8,     32'h202,      0,            0, 0, 1, 1, 0, 32'h80000003, 32'h10,    0,        32'h1880,     1, 32'h200};

        // Reset with IRQ lines high: everything stays zero.
        rst_ni = 1'b0;
        clear_events();
        ext_irq_i = 1'b1; timer_irq_i = 1'b1; sw_irq_i = 1'b1;
        mstatus_i = 32'h8; mie_i = 32'h888; mtvec_i = '0; mepc_i = '0;
        redirect_ready_i = 1'b1;
        repeat (3) step();
        chk("rst mip", mip_o, 32'h0);
        chk("rst strobes", {26'b0, trap_we_o, mret_we_o, is_int_o, stall_o, flush_o, redirect_valid_o}, 32'h0);
        chk("rst data", mepc_o | mcause_o | mtval_o | mstatus_o | redirect_pc_o, 32'h0);
        ext_irq_i = 1'b0; timer_irq_i = 1'b0; sw_irq_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Masked interrupts: no trap, but mip still tracks the lines.
        mstatus_i = 32'h0; mie_i = 32'h888; mtvec_i = 32'h200;
        retire_valid_i = 1'b1;
        ext_irq_i = 1'b1; timer_irq_i = 1'b1; sw_irq_i = 1'b1;
        step();
        chk("mask mip1", mip_o, 32'h088);
        step();
        chk("mask mip2", mip_o, 32'h888);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("mask notrap", {30'b0, trap_we_o, stall_o}, 32'd0);
        end
        clear_events();
        ext_irq_i = 1'b0; timer_irq_i = 1'b0; sw_irq_i = 1'b0;
        repeat (4) step();

        // MRET with fetch backpressure for three redirect cycles.
        mepc_i = 32'h303; mstatus_i = 32'h80; redirect_ready_i = 1'b0;
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        chk("bp mret_we", {30'b0, mret_we_o, trap_we_o}, 32'h2);
        chk("bp mstatus", mstatus_o, 32'h1888);
        chk("bp stall0", {31'b0, stall_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp rd_valid", {31'b0, redirect_valid_o}, 32'd1);
            chk("bp rd_pc", redirect_pc_o, 32'h300);
            chk("bp stall", {31'b0, stall_o}, 32'd1);
            redirect_ready_i = (i == 3);
        end
        step();
        chk("bp done", {30'b0, redirect_valid_o, stall_o}, 32'd0);
        repeat (2) step();

        // Reset while waiting in REDIRECT, then an event right after release.
        redirect_ready_i = 1'b0;
        mstatus_i = 32'h8; mtvec_i = 32'h200;
        exc_valid_i = 1'b1; exc_cause_i = 4'd1; exc_pc_i = 32'h40;
        step();
        clear_events();
        step();
        chk("rr in redirect", {31'b0, redirect_valid_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rr async valid", {30'b0, redirect_valid_o, stall_o}, 32'd0);
        chk("rr async pc", redirect_pc_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        redirect_ready_i = 1'b1;
        exc_valid_i = 1'b1; exc_cause_i = 4'd3; exc_pc_i = 32'h60; exc_tval_i = 32'h7;
        step();
        clear_events();
        chk("rr first trap", {31'b0, trap_we_o}, 32'd1);
        chk("rr first cause", mcause_o, 32'h3);
        chk("rr first mepc", mepc_o, 32'h60);
        step();
        chk("rr redirect", redirect_pc_o, 32'h200);
        step();
        chk("rr idle", {31'b0, stall_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
